// File: rtl/ram_sp_64x23_ctrl_if.sv
// Bundle between the requesters, the single-port SRAM wrapper and the ram_sp_64x23_ctrl arbiter.
// The slave modport is the controller; the master modport is everything around it.
interface ram_sp_64x23_ctrl_if #(
    parameter int unsigned ADR_WD = 6,
    parameter int unsigned DAT_WD = 23
);
    logic              init_req_i;
    logic              init_done_o;
    logic              wr_req_i;
    logic [ADR_WD-1:0] wr_adr_i;
    logic [DAT_WD-1:0] wr_dat_i;
    logic              wr_ack_o;
    logic              rd_req_i;
    logic [ADR_WD-1:0] rd_adr_i;
    logic              rd_ack_o;
    logic              rd_val_o;
    logic [DAT_WD-1:0] rd_dat_o;
    logic [ADR_WD-1:0] adr_o;
    logic              wr_ena_o;
    logic [DAT_WD-1:0] wr_dat_o;
    logic              rd_ena_o;
    logic [DAT_WD-1:0] rd_dat_i;

    modport master (
        output init_req_i, wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i, rd_dat_i,
        input  init_done_o, wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o,
               adr_o, wr_ena_o, wr_dat_o, rd_ena_o
    );

    modport slave (
        input  init_req_i, wr_req_i, wr_adr_i, wr_dat_i, rd_req_i, rd_adr_i, rd_dat_i,
        output init_done_o, wr_ack_o, rd_ack_o, rd_val_o, rd_dat_o,
               adr_o, wr_ena_o, wr_dat_o, rd_ena_o
    );
endinterface

// File: rtl/ram_sp_64x23_ctrl.sv
// Init sweep plus round-robin write/read arbitration for one single-port SRAM.
// Grants are combinational; read data comes straight from the SRAM the cycle after the grant.
module ram_sp_64x23_ctrl #(
    parameter int unsigned       ADR_WD      = 6,
    parameter int unsigned       DAT_WD      = 23,
    parameter logic [DAT_WD-1:0] INIT_VAL    = '0,
    parameter bit                INIT_ON_RST = 1'b1
) (
    input logic                clk,
    input logic                rstn,
    ram_sp_64x23_ctrl_if.slave cif
);
    typedef enum logic {ST_INIT, ST_IDLE} state_e;
    typedef enum logic {PTR_WR, PTR_RD} ptr_e;

    localparam logic [ADR_WD-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    ptr_e              ptr_q, ptr_d;
    logic [ADR_WD-1:0] cnt_q, cnt_d;
    logic              rd_val_q, rd_val_d;
    logic [DAT_WD-1:0] rd_hold_q, rd_hold_d;
    logic              init_done_q, init_done_d;

    logic init_wr;
    logic serve;
    logic grant_wr;
    logic grant_rd;
    logic rd_val;

    // Everything facing the SRAM or the requesters is gated by rstn so reset silences the port at once.
    always_comb begin
        init_wr  = rstn && (state_q == ST_INIT);
        serve    = rstn && (state_q == ST_IDLE) && !cif.init_req_i;
        grant_wr = serve && cif.wr_req_i && (!cif.rd_req_i || (ptr_q == PTR_WR));
        grant_rd = serve && cif.rd_req_i && (!cif.wr_req_i || (ptr_q == PTR_RD));
        rd_val   = rstn && rd_val_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d = '0;
                if (cif.init_req_i) begin
                    state_d = ST_INIT;
                end
            end
        endcase
        if (grant_wr) begin
            ptr_d = PTR_RD;
        end else if (grant_rd) begin
            ptr_d = PTR_WR;
        end
        rd_val_d    = grant_rd;
        rd_hold_d   = rd_val ? cif.rd_dat_i : rd_hold_q;
        init_done_d = (state_q == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= INIT_ON_RST ? ST_INIT : ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= PTR_WR;
            rd_val_q    <= 1'b0;
            rd_hold_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rd_val_q    <= rd_val_d;
            rd_hold_q   <= rd_hold_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        cif.adr_o    = '0;
        cif.wr_dat_o = '0;
        if (init_wr) begin
            cif.adr_o    = cnt_q;
            cif.wr_dat_o = INIT_VAL;
        end else if (grant_wr) begin
            cif.adr_o    = cif.wr_adr_i;
            cif.wr_dat_o = cif.wr_dat_i;
        end else if (grant_rd) begin
            cif.adr_o    = cif.rd_adr_i;
        end
    end

    assign cif.wr_ack_o    = grant_wr;
    assign cif.rd_ack_o    = grant_rd;
    assign cif.wr_ena_o    = init_wr || grant_wr;
    assign cif.rd_ena_o    = grant_rd;
    assign cif.rd_val_o    = rd_val;
    assign cif.rd_dat_o    = rd_val ? cif.rd_dat_i : rd_hold_q;
    assign cif.init_done_o = init_done_q;
endmodule

// File: tb/tb_ram_sp_64x23_ctrl.sv
// Bench for ram_sp_64x23_ctrl: behavioural SRAM, reference memory and a read-data scoreboard.
module tb_ram_sp_64x23_ctrl;
    localparam int unsigned ADR_WD = 6;
    localparam int unsigned DAT_WD = 23;
    localparam int          DEPTH  = 64;
    localparam logic [DAT_WD-1:0] INIT_VAL = '0;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ram_sp_64x23_ctrl_if #(.ADR_WD(ADR_WD), .DAT_WD(DAT_WD)) cif ();

    ram_sp_64x23_ctrl #(
        .ADR_WD(ADR_WD), .DAT_WD(DAT_WD), .INIT_VAL(INIT_VAL), .INIT_ON_RST(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .cif(cif)
    );

    logic [DAT_WD-1:0] sram    [DEPTH];
    logic [DAT_WD-1:0] ref_mem [DEPTH];
    logic [DAT_WD-1:0] exp_q   [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   rd_val_cnt = 0;
    logic ack_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // SRAM wrapper model: write and read both take effect at the clock edge.
    always @(posedge clk) begin
        if (cif.wr_ena_o) sram[cif.adr_o] <= cif.wr_dat_o;
        if (cif.rd_ena_o) cif.rd_dat_i <= sram[cif.adr_o];
    end

    // Monitor: checks every grant on the bus and scores returned read data.
    always @(negedge clk) begin
        logic [DAT_WD-1:0] exp_d;
        if (!rstn) begin
            exp_q.delete();
            ack_prev = 1'b0;
        end else begin
            if (ack_prev || cif.rd_val_o) chk("rd_val_lat", cif.rd_val_o, ack_prev);
            if (cif.rd_val_o) begin
                rd_val_cnt++;
                if (exp_q.size() == 0) chk("rd_q_size", exp_q.size(), 1);
                else begin
                    exp_d = exp_q.pop_front();
                    chk("rd_dat", cif.rd_dat_o, exp_d);
                end
            end
            if (cif.wr_ena_o && cif.rd_ena_o) chk("ena_excl", cif.rd_ena_o, 0);
            if (cif.wr_ack_o) begin
                chk("wr_bus_adr", cif.adr_o, cif.wr_adr_i);
                chk("wr_bus_dat", cif.wr_dat_o, cif.wr_dat_i);
                chk("wr_bus_ena", cif.wr_ena_o, 1);
                ref_mem[cif.wr_adr_i] = cif.wr_dat_i;
            end
            if (cif.rd_ack_o) begin
                chk("rd_bus_adr", cif.adr_o, cif.rd_adr_i);
                chk("rd_bus_ena", cif.rd_ena_o, 1);
                exp_q.push_back(ref_mem[cif.rd_adr_i]);
            end
            ack_prev = cif.rd_ack_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first sweep cycle; returns in the first cycle after the sweep.
    task automatic run_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk({tag, "_wena"}, cif.wr_ena_o, 1);
            chk({tag, "_adr"}, cif.adr_o, i);
            chk({tag, "_wdat"}, cif.wr_dat_o, INIT_VAL);
            chk({tag, "_acks"}, {cif.wr_ack_o, cif.rd_ack_o}, 0);
            if (i == 32) chk({tag, "_done"}, cif.init_done_o, 0);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VAL;
    endtask

    task automatic wait_ack(input bit is_wr, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = is_wr ? cif.wr_ack_o : cif.rd_ack_o;
            tick();
        end
        chk({tag, "_ack"}, got, 1);
    endtask

    task automatic do_write(input logic [ADR_WD-1:0] a, input logic [DAT_WD-1:0] d);
        cif.wr_req_i = 1'b1;
        cif.wr_adr_i = a;
        cif.wr_dat_i = d;
        wait_ack(1'b1, "wr");
        cif.wr_req_i = 1'b0;
    endtask

    task automatic do_read(input logic [ADR_WD-1:0] a);
        cif.rd_req_i = 1'b1;
        cif.rd_adr_i = a;
        wait_ack(1'b0, "rd");
        cif.rd_req_i = 1'b0;
    endtask

    initial begin
        int base;
        rstn = 1'b0;
        cif.init_req_i = 1'b0;
        cif.wr_req_i = 1'b0;
        cif.wr_adr_i = '0;
        cif.wr_dat_i = '0;
        cif.rd_req_i = 1'b0;
        cif.rd_adr_i = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wena", cif.wr_ena_o, 0);
        chk("rst_rena", cif.rd_ena_o, 0);
        chk("rst_adr", cif.adr_o, 0);
        chk("rst_wdat", cif.wr_dat_o, 0);
        chk("rst_done", cif.init_done_o, 0);
        chk("rst_rval", cif.rd_val_o, 0);
        chk("rst_rdat", cif.rd_dat_o, 0);
        tick();
        rstn = 1'b1;

        // Power-up sweep, then idle bus and read back an initialised entry.
        run_sweep("sw1");
        @(negedge clk);
        chk("idle_wena", cif.wr_ena_o, 0);
        chk("idle_adr", cif.adr_o, 0);
        tick();
        @(negedge clk);
        chk("init_done", cif.init_done_o, 1);
        tick();
        base = rd_val_cnt;
        do_read(6'd63);
        tick();
        tick();
        chk("t1_nval", rd_val_cnt - base, 1);

        // Write then read the same address in consecutive cycles.
        base = rd_val_cnt;
        do_write(6'd5, 23'h2A5A5A);
        do_read(6'd5);
        tick();
        tick();
        chk("t2_nval", rd_val_cnt - base, 1);
        chk("t2_qempty", exp_q.size(), 0);

        // Both requesters held through reset and sweep: strict alternation starting with write.
        cif.wr_req_i = 1'b1;
        cif.rd_req_i = 1'b1;
        cif.wr_adr_i = 6'd20;
        cif.rd_adr_i = 6'd20;
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_acks", {cif.wr_ack_o, cif.rd_ack_o}, 0);
        tick();
        rstn = 1'b1;
        run_sweep("sw2");
        base = rd_val_cnt;
        for (int k = 0; k < 6; k++) begin
            cif.wr_dat_i = 23'(100 + k);
            @(negedge clk);
            chk("rr_wack", cif.wr_ack_o, (k % 2) == 0);
            chk("rr_rack", cif.rd_ack_o, (k % 2) == 1);
            tick();
        end
        cif.wr_req_i = 1'b0;
        cif.rd_req_i = 1'b0;
        tick();
        tick();
        chk("t3_nval", rd_val_cnt - base, 3);

        // Re-init request wins over a pending read; read is served after the sweep.
        base = rd_val_cnt;
        cif.init_req_i = 1'b1;
        cif.rd_req_i = 1'b1;
        cif.rd_adr_i = 6'd20;
        @(negedge clk);
        chk("ireq_prio", cif.rd_ack_o, 0);
        tick();
        cif.init_req_i = 1'b0;
        run_sweep("sw3");
        wait_ack(1'b0, "t4");
        cif.rd_req_i = 1'b0;
        tick();
        chk("t4_nval", rd_val_cnt - base, 1);

        // Reset in the middle of a sweep restarts it from address 0.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("sw4_adr", cif.adr_o, i);
            tick();
        end
        rstn = 1'b0;
        cif.wr_req_i = 1'b1;
        cif.wr_adr_i = 6'd7;
        cif.wr_dat_i = 23'h000777;
        @(negedge clk);
        chk("t5_wena", cif.wr_ena_o, 0);
        chk("t5_rena", cif.rd_ena_o, 0);
        chk("t5_adr", cif.adr_o, 0);
        chk("t5_wack", cif.wr_ack_o, 0);
        tick();
        rstn = 1'b1;
        run_sweep("sw5");
        wait_ack(1'b1, "t5");
        cif.wr_req_i = 1'b0;

        // Reset right after a read grant suppresses its data and clears the held value.
        do_write(6'd5, 23'h001234);
        do_read(6'd5);
        tick();
        @(negedge clk);
        chk("t6_hold", cif.rd_dat_o, 23'h001234);
        tick();
        base = rd_val_cnt;
        cif.rd_req_i = 1'b1;
        cif.rd_adr_i = 6'd5;
        @(negedge clk);
        chk("t6_rack", cif.rd_ack_o, 1);
        tick();
        rstn = 1'b0;
        cif.rd_req_i = 1'b0;
        @(negedge clk);
        chk("t6_rval_rst", cif.rd_val_o, 0);
        tick();
        rstn = 1'b1;
        chk("t6_rval_post", cif.rd_val_o, 0);
        chk("t6_rdat_post", cif.rd_dat_o, 0);
        run_sweep("sw6");
        chk("t6_nval", rd_val_cnt - base, 0);
        chk("t6_rdat_end", cif.rd_dat_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
